// File: rtl/alu_tester_if.sv
// Bus between the tester and the ALU under test: operands and opcode go out,
// the combinational result comes back in the same cycle.
interface alu_tester_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  ALUOp;
  logic [31:0] C;

  // Handshake: there is no valid/ready pair. A/B/ALUOp are registered by the
  // master and stay stable for a whole cycle; the slave answers combinationally
  // on C, and the master samples C on the next rising edge.
  modport master (output A, output B, output ALUOp, input C);
  modport slave  (input A, input B, input ALUOp, output C);
endinterface

// File: rtl/alu_tester.sv
// Self-test engine for a 32-bit ALU: drives LFSR-generated vectors, one per
// cycle, checks the ALU result against a golden model and tallies mismatches.
module alu_tester (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [31:0]         seed,
  input  logic [15:0]         num_vec,
  alu_tester_if.master        bus,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         err_cnt,
  output logic [15:0]         first_fail,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic [31:0] lfsr;
  logic [15:0] k;
  logic [15:0] nv;
  logic [16:0] k_inc;
  logic [31:0] seed_fix;
  logic [31:0] src_l;
  logic [31:0] ld_b_raw;
  logic [31:0] ld_b;
  logic [31:0] ld_lfsr;
  logic [2:0]  ld_op;
  logic [31:0] golden;
  logic        mismatch;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  assign k_inc    = {1'b0, k} + 17'd1;
  assign seed_fix = (seed == 32'd0) ? 32'd1 : seed;

  // Next vector: vector 0 comes from the seed on an accepted start, later
  // vectors continue from the stored LFSR state. Shift opcodes get a 5-bit B.
  always_comb begin
    src_l    = accept ? seed_fix : lfsr;
    ld_op    = accept ? 3'd0 : k_inc[2:0];
    ld_b_raw = lfsr_step(src_l);
    ld_b     = ld_b_raw;
    if (ld_op == 3'b100 || ld_op == 3'b101) ld_b = ld_b_raw & 32'h0000_001F;
    ld_lfsr  = lfsr_step(ld_b_raw);
  end

  // Golden ALU result for the vector currently on the bus.
  always_comb begin
    golden = 32'd0;
    case (bus.ALUOp)
      3'b000:  golden = bus.A + bus.B;
      3'b001:  golden = bus.A - bus.B;
      3'b010:  golden = bus.A & bus.B;
      3'b011:  golden = bus.A | bus.B;
      3'b100:  golden = bus.A >> bus.B[4:0];
      3'b101:  golden = $unsigned($signed(bus.A) >>> bus.B[4:0]);
      default: golden = 32'd0;
    endcase
    mismatch = (bus.C != golden);
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic; start is only honoured outside RUN.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = (num_vec != 16'd0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (k_inc >= {1'b0, nv}) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Vector generation and result bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.A      <= 32'd0;
      bus.B      <= 32'd0;
      bus.ALUOp  <= 3'd0;
      lfsr       <= 32'd1;
      k          <= 16'd0;
      nv         <= 16'd0;
      err_cnt    <= 16'd0;
      first_fail <= 16'hFFFF;
    end else if (accept) begin
      bus.A      <= src_l;
      bus.B      <= ld_b;
      bus.ALUOp  <= ld_op;
      lfsr       <= ld_lfsr;
      k          <= 16'd0;
      nv         <= num_vec;
      err_cnt    <= 16'd0;
      first_fail <= 16'hFFFF;
    end else if (state == RUN) begin
      if (mismatch) begin
        if (err_cnt != 16'hFFFF)    err_cnt    <= err_cnt + 16'd1;
        if (first_fail == 16'hFFFF) first_fail <= k;
      end
      if (state_next == RUN) begin
        bus.A     <= src_l;
        bus.B     <= ld_b;
        bus.ALUOp <= ld_op;
        lfsr      <= ld_lfsr;
        k         <= k_inc[15:0];
      end
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign pass      = (state == DONE) && (err_cnt == 16'd0);
  assign state_dbg = state;

endmodule
